ber_run_ctrl: RTL and testbench

Run sequencer for one 2-bit-symbol error-injection channel in the BER simulator. It latches a run configuration, resets and seeds the channel, streams a programmed number of symbols through it, and compares each channel output against the symbol sent. It accumulates symbol-error, burst-count and max-burst-length statistics, and reports done/busy to the host-side register block.

---
 rtl/ber_run_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_ber_run_ctrl.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ber_run_ctrl.sv
// ----------------------------------------------------------------------------
// ber_run_ctrl
//
// Run sequencer for one 2-bit-symbol error-injection channel of the BER
// simulator. On an accepted start it latches the run configuration, holds the
// channel in reset for INIT_CYCLES cycles, and then streams cfg_num_symbols
// symbols from a free-running 2-bit counter (0,1,2,3,0,...). Each channel
// output is compared against the symbol that was sent, and the block keeps
// symbol, error, burst and longest-burst statistics. All outputs are
// registered.
//
// Ports
//   clk, rstn          clock, synchronous active-low reset
//   start, abort       single-cycle run control pulses (abort wins)
//   hold               suppresses symbol issue while high in RUN
//   cfg_*              run configuration, sampled only on an accepted start
//   chan_rstn, chan_en channel reset (active-low) and symbol strobe
//   chan_epf_en, chan_seed0/1/2  latched channel configuration
//   chan_symbol_in     symbol sent to the channel
//   chan_symbol_out    channel output, qualified by chan_valid
//   busy, done         run status for the host register block
//   sym_cnt, err_cnt, burst_cnt, max_burst  saturating run statistics
// ----------------------------------------------------------------------------
module ber_run_ctrl #(
   parameter int CNT_W       = 48,
   parameter int INIT_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic             abort,
   input  logic             hold,
   input  logic [CNT_W-1:0] cfg_num_symbols,
   input  logic             cfg_epf_en,
   input  logic [63:0]      cfg_seed0,
   input  logic [63:0]      cfg_seed1,
   input  logic [63:0]      cfg_seed2,
   output logic             chan_rstn,
   output logic             chan_en,
   output logic             chan_epf_en,
   output logic [63:0]      chan_seed0,
   output logic [63:0]      chan_seed1,
   output logic [63:0]      chan_seed2,
   output logic [1:0]       chan_symbol_in,
   input  logic [1:0]       chan_symbol_out,
   input  logic             chan_valid,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] sym_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] burst_cnt,
   output logic [CNT_W-1:0] max_burst
);

   localparam int                INIT_W    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [INIT_W-1:0] init_cnt;
   logic [CNT_W-1:0]  num_sym;
   logic [CNT_W-1:0]  issue_cnt;
   logic [CNT_W-1:0]  burst_len;
   logic [CNT_W-1:0]  burst_len_inc;
   logic [1:0]        exp_sym;
   logic              start_acc;
   logic              last_issue;
   logic              chan_en_nxt;
   logic              chan_rstn_nxt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   // chan_en is only ever high in RUN, so a strobe with issue_cnt at N-1 is
   // the final symbol of the run.
   assign last_issue    = chan_en && (issue_cnt == num_sym - CNT_W'(1));
   assign burst_len_inc = sat_inc(burst_len);

   // ---------------------------------------------------------------------------
   // Next-state and next-output decode
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it
      // unassigned; otherwise synthesis infers a latch.
      state_nxt     = state;
      chan_en_nxt   = 1'b0;
      chan_rstn_nxt = 1'b0;
      start_acc     = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) begin
               start_acc = 1'b1;
               state_nxt = S_INIT;
            end
         end
         S_INIT: begin
            if (init_cnt == INIT_LAST) begin
               chan_rstn_nxt = 1'b1;
               state_nxt     = (num_sym == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            chan_rstn_nxt = 1'b1;
            if (last_issue) begin
               state_nxt = S_DRAIN;
            end else begin
               chan_en_nxt = !hold;
            end
         end
         S_DRAIN: begin
            chan_rstn_nxt = 1'b1;
            // The final chan_valid lands one cycle after the last strobe.
            if (sym_cnt == num_sym) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            chan_rstn_nxt = 1'b1;
            if (start) begin
               start_acc     = 1'b1;
               chan_rstn_nxt = 1'b0;
               state_nxt     = S_INIT;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      // Abort overrides everything, including a start in the same cycle.
      if (abort) begin
         state_nxt     = S_IDLE;
         chan_en_nxt   = 1'b0;
         chan_rstn_nxt = 1'b0;
         start_acc     = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!rstn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Registered outputs, configuration latch and statistics
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rstn) begin
         chan_rstn      <= 1'b0;
         chan_en        <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         init_cnt       <= '0;
         num_sym        <= '0;
         chan_epf_en    <= 1'b0;
         chan_seed0     <= '0;
         chan_seed1     <= '0;
         chan_seed2     <= '0;
         issue_cnt      <= '0;
         chan_symbol_in <= '0;
         exp_sym        <= '0;
         burst_len      <= '0;
         sym_cnt        <= '0;
         err_cnt        <= '0;
         burst_cnt      <= '0;
         max_burst      <= '0;
      end else begin
         chan_rstn <= chan_rstn_nxt;
         chan_en   <= chan_en_nxt;
         busy      <= (state_nxt == S_INIT) || (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
         done      <= (state_nxt == S_DONE);
         init_cnt  <= ((state == S_INIT) && (state_nxt == S_INIT)) ? init_cnt + INIT_W'(1) : '0;

         if (start_acc) begin
            num_sym        <= cfg_num_symbols;
            chan_epf_en    <= cfg_epf_en;
            chan_seed0     <= cfg_seed0;
            chan_seed1     <= cfg_seed1;
            chan_seed2     <= cfg_seed2;
            issue_cnt      <= '0;
            chan_symbol_in <= '0;
            exp_sym        <= '0;
            burst_len      <= '0;
            sym_cnt        <= '0;
            err_cnt        <= '0;
            burst_cnt      <= '0;
            max_burst      <= '0;
         end else begin
            // Issue cycle: the symbol on chan_symbol_in is taken by the channel.
            if (chan_en) begin
               issue_cnt      <= sat_inc(issue_cnt);
               chan_symbol_in <= chan_symbol_in + 2'd1;
               exp_sym        <= chan_symbol_in;
            end

            // Hold gaps produce no chan_valid, so they never break a burst.
            if (chan_valid && busy) begin
               sym_cnt <= sat_inc(sym_cnt);
               if (chan_symbol_out != exp_sym) begin
                  err_cnt   <= sat_inc(err_cnt);
                  burst_len <= burst_len_inc;
                  if (burst_len == '0) begin
                     burst_cnt <= sat_inc(burst_cnt);
                  end
                  if (burst_len_inc > max_burst) begin
                     max_burst <= burst_len_inc;
                  end
               end else begin
                  burst_len <= '0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ber_run_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ber_run_ctrl
//
// Bench for ber_run_ctrl with a behavioural channel stub that echoes each
// strobed symbol one cycle later, optionally corrupted (+1 mod 4) according
// to a per-issue table. Expected symbols and end-of-run statistics are queued
// when a run is launched; independent monitors pop and compare them when the
// DUT strobes a symbol or raises done.
// ----------------------------------------------------------------------------
module tb_ber_run_ctrl;

   localparam int CNT_W       = 48;
   localparam int INIT_CYCLES = 4;
   localparam int BUDGET      = 3000;

   typedef struct {
      longint sym;
      longint err;
      longint bursts;
      longint maxb;
   } stats_t;

   logic             clk = 1'b0;
   logic             rstn;
   logic             start;
   logic             abort;
   logic             hold;
   logic [CNT_W-1:0] cfg_num_symbols;
   logic             cfg_epf_en;
   logic [63:0]      cfg_seed0;
   logic [63:0]      cfg_seed1;
   logic [63:0]      cfg_seed2;
   logic             chan_rstn;
   logic             chan_en;
   logic             chan_epf_en;
   logic [63:0]      chan_seed0;
   logic [63:0]      chan_seed1;
   logic [63:0]      chan_seed2;
   logic [1:0]       chan_symbol_in;
   logic [1:0]       chan_symbol_out = 2'd0;
   logic             chan_valid = 1'b0;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] sym_cnt;
   logic [CNT_W-1:0] err_cnt;
   logic [CNT_W-1:0] burst_cnt;
   logic [CNT_W-1:0] max_burst;

   always #5 clk = ~clk;

   ber_run_ctrl #(
      .CNT_W       (CNT_W),
      .INIT_CYCLES (INIT_CYCLES)
   ) dut (
      .clk             (clk),
      .rstn            (rstn),
      .start           (start),
      .abort           (abort),
      .hold            (hold),
      .cfg_num_symbols (cfg_num_symbols),
      .cfg_epf_en      (cfg_epf_en),
      .cfg_seed0       (cfg_seed0),
      .cfg_seed1       (cfg_seed1),
      .cfg_seed2       (cfg_seed2),
      .chan_rstn       (chan_rstn),
      .chan_en         (chan_en),
      .chan_epf_en     (chan_epf_en),
      .chan_seed0      (chan_seed0),
      .chan_seed1      (chan_seed1),
      .chan_seed2      (chan_seed2),
      .chan_symbol_in  (chan_symbol_in),
      .chan_symbol_out (chan_symbol_out),
      .chan_valid      (chan_valid),
      .busy            (busy),
      .done            (done),
      .sym_cnt         (sym_cnt),
      .err_cnt         (err_cnt),
      .burst_cnt       (burst_cnt),
      .max_burst       (max_burst)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model and scoreboard queues
   // ---------------------------------------------------------------------------
   bit         corrupt_tbl [256];
   logic [1:0] sym_q [$];
   stats_t     stats_q [$];

   // Statistics follow directly from the corruption pattern: each maximal run
   // of corrupted symbols is one burst.
   function automatic stats_t model(input int n);
      stats_t s;
      int     run_len;
      s       = '{default: 0};
      run_len = 0;
      s.sym   = n;
      for (int i = 0; i < n; i++) begin
         if (corrupt_tbl[i]) begin
            s.err   += 1;
            run_len += 1;
            if (run_len == 1) s.bursts += 1;
            if (run_len > s.maxb) s.maxb = run_len;
         end else begin
            run_len = 0;
         end
      end
      return s;
   endfunction

   // ---------------------------------------------------------------------------
   // Channel stub: output valid one cycle after the strobe
   // ---------------------------------------------------------------------------
   int         stub_idx = 0;
   bit         pend_v   = 1'b0;
   logic [1:0] pend_sym = 2'd0;

   always @(negedge clk) begin
      if (start === 1'b1) stub_idx = 0;
      pend_v = (chan_en === 1'b1);
      if (pend_v) begin
         pend_sym = (stub_idx < 256 && corrupt_tbl[stub_idx]) ? chan_symbol_in + 2'd1 : chan_symbol_in;
         stub_idx++;
      end else begin
         pend_sym = 2'($urandom);
      end
   end

   always @(posedge clk) begin
      #1;
      chan_valid      = pend_v;
      chan_symbol_out = pend_sym;
   end

   // ---------------------------------------------------------------------------
   // Monitors
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      if (chan_en === 1'b1) begin
         if (sym_q.size() == 0) check("unexpected_issue", 64'(chan_en), 64'(0));
         else check("symbol_in", 64'(chan_symbol_in), 64'(sym_q.pop_front()));
         check("chan_rstn_at_issue", 64'(chan_rstn), 64'(1));
      end
   end

   logic   done_prev = 1'b0;
   stats_t st_mon;

   always @(negedge clk) begin
      if (done === 1'b1 && done_prev !== 1'b1) begin
         if (stats_q.size() == 0) begin
            check("unexpected_done", 64'(done), 64'(0));
         end else begin
            st_mon = stats_q.pop_front();
            check("sym_cnt", 64'(sym_cnt), 64'(st_mon.sym));
            check("err_cnt", 64'(err_cnt), 64'(st_mon.err));
            check("burst_cnt", 64'(burst_cnt), 64'(st_mon.bursts));
            check("max_burst", 64'(max_burst), 64'(st_mon.maxb));
         end
      end
      done_prev = done;
   end

   // ---------------------------------------------------------------------------
   // Stimulus tasks
   // ---------------------------------------------------------------------------
   task automatic clear_mask();
      foreach (corrupt_tbl[i]) corrupt_tbl[i] = 1'b0;
   endtask

   task automatic random_mask();
      int thr;
      thr = $urandom_range(0, 3);
      foreach (corrupt_tbl[i]) corrupt_tbl[i] = ($urandom_range(0, 7) < thr);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'(0));
      check({tag, "_done"}, 64'(done), 64'(0));
      check({tag, "_chan_en"}, 64'(chan_en), 64'(0));
      check({tag, "_chan_rstn"}, 64'(chan_rstn), 64'(0));
      check({tag, "_symbol_in"}, 64'(chan_symbol_in), 64'(0));
      check({tag, "_sym_cnt"}, 64'(sym_cnt), 64'(0));
      check({tag, "_err_cnt"}, 64'(err_cnt), 64'(0));
      check({tag, "_burst_cnt"}, 64'(burst_cnt), 64'(0));
      check({tag, "_max_burst"}, 64'(max_burst), 64'(0));
      check({tag, "_seed0"}, chan_seed0, 64'(0));
      check({tag, "_seed1"}, chan_seed1, 64'(0));
      check({tag, "_seed2"}, chan_seed2, 64'(0));
      check({tag, "_epf_en"}, 64'(chan_epf_en), 64'(0));
   endtask

   // Reset with start held high: the start must not survive reset.
   task automatic do_reset();
      rstn  = 1'b0;
      start = 1'b1;
      abort = 1'b0;
      hold  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk);
      #1;
      rstn  = 1'b1;
      start = 1'b0;
      @(negedge clk);
      check("start_in_reset_busy", 64'(busy), 64'(0));
      check("start_in_reset_rstn", 64'(chan_rstn), 64'(0));
   endtask

   // hold_mode: 0 none, 1 random, 2 three-cycle gap after the 2nd issue.
   // kill_kind: 0 none, 1 abort, 2 reset, applied after issue kill_at.
   task automatic run(input int n, input int hold_mode, input int kill_kind,
                      input int kill_at, input bit poke_start);
      logic [63:0] s0, s1, s2;
      logic        epf;
      int          low, issues, first_en, hold_left;
      bit          seen_high, hold_used, killed, finished;

      s0        = {$urandom, $urandom};
      s1        = {$urandom, $urandom};
      s2        = {$urandom, $urandom};
      epf       = 1'($urandom_range(0, 1));
      low       = 0;
      issues    = 0;
      first_en  = 0;
      hold_left = 0;
      seen_high = 1'b0;
      hold_used = 1'b0;
      killed    = 1'b0;
      finished  = 1'b0;

      for (int i = 0; i < n; i++) sym_q.push_back(2'(i % 4));
      if (kill_kind == 0) stats_q.push_back(model(n));

      @(posedge clk);
      #1;
      cfg_num_symbols = CNT_W'(n);
      cfg_epf_en      = epf;
      cfg_seed0       = s0;
      cfg_seed1       = s1;
      cfg_seed2       = s2;
      start           = 1'b1;
      @(posedge clk);
      #1;
      start           = 1'b0;
      // Config changes after start must not affect this run.
      cfg_num_symbols = CNT_W'($urandom_range(1, 200));
      cfg_epf_en      = ~epf;
      cfg_seed0       = ~s0;
      cfg_seed1       = ~s1;
      cfg_seed2       = ~s2;

      for (int k = 1; k <= BUDGET && !finished; k++) begin
         @(negedge clk);
         if (k == 1) begin
            check("start_busy", 64'(busy), 64'(1));
            check("start_done", 64'(done), 64'(0));
            check("start_sym_cnt_clr", 64'(sym_cnt), 64'(0));
            check("start_err_cnt_clr", 64'(err_cnt), 64'(0));
            check("start_burst_cnt_clr", 64'(burst_cnt), 64'(0));
            check("start_max_burst_clr", 64'(max_burst), 64'(0));
            check("seed0_latched", chan_seed0, s0);
            check("seed1_latched", chan_seed1, s1);
            check("seed2_latched", chan_seed2, s2);
            check("epf_latched", 64'(chan_epf_en), 64'(epf));
         end
         if (!seen_high) begin
            if (chan_rstn === 1'b0) low++;
            else seen_high = 1'b1;
         end
         if (chan_en === 1'b1) begin
            issues++;
            if (first_en == 0) first_en = k;
         end

         if (killed) begin
            abort = 1'b0;
            rstn  = 1'b1;
            if (kill_kind == 1) begin
               check("abort_chan_en", 64'(chan_en), 64'(0));
               check("abort_busy", 64'(busy), 64'(0));
               check("abort_done", 64'(done), 64'(0));
               check("abort_chan_rstn", 64'(chan_rstn), 64'(0));
               check("abort_sym_cnt_range",
                     64'((sym_cnt == CNT_W'(kill_at - 1)) || (sym_cnt == CNT_W'(kill_at))), 64'(1));
               check("abort_err_cnt", 64'(err_cnt), 64'(0));
            end else begin
               check_all_zero("midrun_reset");
            end
            sym_q.delete();
            finished = 1'b1;
         end else if (done === 1'b1) begin
            finished = 1'b1;
         end else begin
            start = poke_start && (k == 2);
            if (hold_mode == 1) begin
               hold = ($urandom_range(0, 3) == 0);
            end else if (hold_mode == 2) begin
               if (issues == 2 && !hold_used) begin
                  hold_used = 1'b1;
                  hold_left = 3;
               end
               hold = (hold_left > 0);
               if (hold_left > 0) hold_left--;
            end
            if (kill_kind != 0 && issues == kill_at) begin
               killed = 1'b1;
               hold   = 1'b0;
               start  = 1'b0;
               if (kill_kind == 1) abort = 1'b1;
               else rstn = 1'b0;
            end
         end
      end

      start = 1'b0;
      hold  = 1'b0;
      abort = 1'b0;
      rstn  = 1'b1;
      check("run_completed_in_budget", 64'(finished), 64'(1));
      if (!finished) begin
         sym_q.delete();
         stats_q.delete();
      end else if (kill_kind == 0) begin
         check("issue_count", 64'(issues), 64'(n));
         check("chan_rstn_low_cycles", 64'(low), 64'(INIT_CYCLES));
         if (hold_mode == 0 && n > 0) check("start_to_chan_en", 64'(first_en), 64'(INIT_CYCLES + 2));
         check("symbols_outstanding", 64'(sym_q.size()), 64'(0));
         check("seed0_held", chan_seed0, s0);
         check("seed1_held", chan_seed1, s1);
         check("seed2_held", chan_seed2, s2);
         check("epf_held", 64'(chan_epf_en), 64'(epf));
         check("done_busy", 64'(busy), 64'(0));
         check("done_chan_en", 64'(chan_en), 64'(0));
         check("done_chan_rstn", 64'(chan_rstn), 64'(1));
      end
   endtask

   // After an abort: statistics stay frozen, and start+abort together is ignored.
   task automatic abort_freeze_and_collision();
      logic [63:0] frozen;
      @(negedge clk);
      frozen = 64'(sym_cnt);
      @(posedge clk);
      #1;
      cfg_num_symbols = CNT_W'(5);
      start           = 1'b1;
      abort           = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("collide_busy", 64'(busy), 64'(0));
         check("collide_done", 64'(done), 64'(0));
         check("collide_chan_rstn", 64'(chan_rstn), 64'(0));
         check("collide_chan_en", 64'(chan_en), 64'(0));
         check("frozen_sym_cnt", 64'(sym_cnt), frozen);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Test sequence
   // ---------------------------------------------------------------------------
   initial begin
      rstn            = 1'b0;
      start           = 1'b0;
      abort           = 1'b0;
      hold            = 1'b0;
      cfg_num_symbols = '0;
      cfg_epf_en      = 1'b0;
      cfg_seed0       = '0;
      cfg_seed1       = '0;
      cfg_seed2       = '0;
      clear_mask();

      do_reset();

      // Pass-through run.
      run(8, 0, 0, 0, 1'b0);

      // Corrupt symbols 3, 4, 5 and 10; restarts from DONE.
      clear_mask();
      corrupt_tbl[2] = 1'b1;
      corrupt_tbl[3] = 1'b1;
      corrupt_tbl[4] = 1'b1;
      corrupt_tbl[9] = 1'b1;
      run(12, 0, 0, 0, 1'b0);

      // Hold gap in the middle of a two-symbol burst.
      clear_mask();
      corrupt_tbl[1] = 1'b1;
      corrupt_tbl[2] = 1'b1;
      run(6, 2, 0, 0, 1'b0);

      // Zero-length run.
      clear_mask();
      run(0, 0, 0, 0, 1'b0);

      // Randomized runs, some with a start pulse while busy.
      for (int r = 0; r < 12; r++) begin
         random_mask();
         run($urandom_range(1, 40), $urandom_range(0, 1), 0, 0, (r % 3) == 0);
      end

      // Abort after the 20th issue, then freeze and start+abort collision.
      clear_mask();
      run(100, 0, 1, 20, 1'b0);
      abort_freeze_and_collision();

      // A run from IDLE after the abort, then a reset in the middle of a run.
      random_mask();
      run(10, 1, 0, 0, 1'b0);
      run(50, 0, 2, 10, 1'b0);

      repeat (3) @(negedge clk);
      check("stats_outstanding", 64'(stats_q.size()), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no end, expected $finish");
      $fatal(1, "watchdog");
   end

endmodule
